cordic_rotator: RTL
===================

Name: cordic_rotator

Overview:
- Iterative, one-micro-rotation-per-cycle CORDIC engine in rotation mode. Computes cos/sin of a signed angle given in degrees.
- Sits directly downstream of the arctangent ROM. It drives the ROM address with its iteration counter and consumes the combinational Q8.8-degree arctangent word in the same cycle.
- Feeds sin/cos results to downstream datapath consumers through a start/done handshake.

Parameters:
- Width, 16, data width of angle, ROM word and x/y results. Only 16 is supported; the constants below are tied to it.
- Iters, 16, number of micro-rotations, legal range 1..16 (ROM depth).
- KInit, 9949, initial x value: CORDIC gain 1/An = 0.607253 in Q2.14. Valid for Iters >= 12.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  request; sampled only in IDLE
- angle_i  in  Width  signed angle, degrees, Q8.8 (e.g. 30.0 deg = 7680)
- rom_addr_o  out  4  arctan ROM address = current iteration index
- rom_data_i  in  Width  arctan(2^-i) from ROM, unsigned Q8.8 degrees, combinational on rom_addr_o
- busy_o  out  1  high in RUN and DONE
- done_o  out  1  one-cycle pulse; x_o/y_o valid from this cycle on
- x_o  out  Width  signed cos result, Q2.14 (1.0 = 16384)
- y_o  out  Width  signed sin result, Q2.14

Behaviour:
- Reset (async assert, any state): state=IDLE, iteration counter=0, internal x/y/z=0, x_o=0, y_o=0, busy_o=0, done_o=0, rom_addr_o=0. Takes effect mid-computation; the aborted job produces no done_o.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 at an edge: clamp angle_i to [-23040, +23040] (±90.0 deg).
  - Load z=clamped angle, x=KInit<<2, y=0, i=0. Go to RUN.
- RUN, each edge:
  - d=+1 if z>=0, else -1.
  - x' = x - d*(y>>>i)
  - y' = y + d*(x>>>i)
  - z' = z - d*rom_data_i
  - i' = i+1
  - When the edge processes i=Iters-1: go to DONE and register the outputs from the final x', y'.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge E0. Iterations occur at edges E1..E_Iters. done_o is high in the cycle after E_Iters, i.e. 17 cycles after E0 for Iters=16. A new start can be accepted at the edge ending the DONE cycle + 1, giving a throughput of one result per Iters+2 cycles.
- Internal arithmetic:
  - x/y are signed Width+2 bits (2 guard fractional bits).
  - Shifts are arithmetic.
  - z is signed Width+1 bits; no overflow is possible inside the clamped range.
- Output conversion: round half-up (add 2, shift right 2), then saturate to [-16384, +16384].
- x_o/y_o hold their value until the next completion. They do not change during RUN.
- start_i in RUN/DONE is ignored, with no queueing.
- start_i held high continuously launches back-to-back jobs, each sampling angle_i at its own IDLE edge.
- rom_addr_o = i in RUN; 0 in IDLE/DONE.
- angle_i is don't-care outside the sampling edge.

Test Plan:
- Reset mid-RUN (assert at iteration 7) -> same cycle busy_o=0, x_o=y_o=0. No done_o within 40 cycles. Next start runs normally.
- angle_i=0 -> done_o 17 cycles after start; x_o=16384±8, y_o=0±8.
- angle_i=7680 (30 deg) -> x_o=14189±8, y_o=8192±8. angle_i=-11520 (-45 deg) -> x_o=11585±8, y_o=-11585±8.
- angle_i=23040 (90 deg) -> x_o=0±8, y_o=16384±8. angle_i=30720 (120 deg, clamped) -> identical result. angle_i=-32768 -> x_o=0±8, y_o=-16384±8.
- Pulse start_i during RUN with a different angle -> ignored. Exactly one done_o, carrying the original angle's result. busy_o continuous for 17 cycles.
- start_i held high with angles 0 then 7680 -> two done_o pulses 18 cycles apart with the correct results. rom_addr_o sequences 0..15 during each RUN.

Source files
------------

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, producing cos/sin of a
// signed Q8.8-degree angle as Q2.14 values, fed by an external combinational arctan ROM.
module cordic_rotator #(
    parameter int Width = 16,
    parameter int Iters = 16,
    parameter int KInit = 9949
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] angle_i,
    output logic [3:0]       rom_addr_o,
    input  logic [Width-1:0] rom_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] x_o,
    output logic [Width-1:0] y_o
);

    localparam int XW = Width + 2;
    localparam int ZW = Width + 1;

    localparam logic signed [Width-1:0] AngleMax = Width'(23040);
    localparam logic signed [Width-1:0] AngleMin = Width'(-23040);
    localparam logic signed [XW-1:0]    XInit    = XW'(KInit * 4);
    localparam logic signed [XW-1:0]    OutMax   = XW'(16384);
    localparam logic signed [XW-1:0]    OutMin   = XW'(-16384);
    localparam logic [3:0]              LastIter = 4'(Iters - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state;
    logic [3:0]              iter;
    logic signed [XW-1:0]    x;
    logic signed [XW-1:0]    y;
    logic signed [ZW-1:0]    z;

    logic signed [Width-1:0] angle_s;
    logic signed [Width-1:0] angle_clamped;
    logic signed [ZW-1:0]    rom_ext;
    logic signed [XW-1:0]    x_next;
    logic signed [XW-1:0]    y_next;
    logic signed [ZW-1:0]    z_next;

    // Rotation range is limited to +/-90 degrees so the CORDIC convergence range covers it.
    always_comb begin
        angle_s = signed'(angle_i);
        if (angle_s > AngleMax) begin
            angle_clamped = AngleMax;
        end else if (angle_s < AngleMin) begin
            angle_clamped = AngleMin;
        end else begin
            angle_clamped = angle_s;
        end
    end

    always_comb begin
        rom_ext = signed'({1'b0, rom_data_i});
        if (z[ZW-1]) begin
            x_next = x + (y >>> iter);
            y_next = y - (x >>> iter);
            z_next = z + rom_ext;
        end else begin
            x_next = x - (y >>> iter);
            y_next = y + (x >>> iter);
            z_next = z - rom_ext;
        end
    end

    // Drops the two guard bits with round-half-up, then limits to exactly +/-1.0.
    function automatic logic [Width-1:0] round_sat(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] r;
        r = (v + XW'(2)) >>> 2;
        if (r > OutMax) begin
            r = OutMax;
        end else if (r < OutMin) begin
            r = OutMin;
        end
        return r[Width-1:0];
    endfunction

    assign rom_addr_o = iter;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            iter   <= '0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            x_o    <= '0;
            y_o    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        z      <= ZW'(angle_clamped);
                        x      <= XInit;
                        y      <= '0;
                        iter   <= '0;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    x <= x_next;
                    y <= y_next;
                    z <= z_next;
                    if (iter == LastIter) begin
                        iter   <= '0;
                        x_o    <= round_sat(x_next);
                        y_o    <= round_sat(y_next);
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        iter <= iter + 4'd1;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
